// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, default widths and the lock FSM state type.
// Consumed by alu_share_arbiter (lock state used only when ALU_ARB_LOCK_EN is defined).
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    LOCK0    = 2'b01,
    LOCK1    = 2'b10
  } lock_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant picker: one-hot grant, ties go to the requester
// that was not granted last; masked requesters are never granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic [1:0] req_eff_s;

  assign req_eff_s = req & ~mask;

  // Grant selection from the effective (unmasked) request vector.
  always_comb begin
    grant = 2'b00;
    if (!enable) begin
      grant = 2'b00;
    end else begin
      case (req_eff_s)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters and buffers
// one response. Optional grant locking is enabled by defining ALU_ARB_LOCK_EN.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
`ifdef ALU_ARB_LOCK_EN
  input  logic              req0_lock,
  input  logic              req1_lock,
`endif
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
);

  logic              can_accept_s;
  logic [1:0]        grant_s;
  logic [1:0]        mask_s;
  logic              xfer_s;
  logic              grant_idx_s;
  logic              last_grant_r;
  logic              rsp_valid_r;
  logic              rsp_id_r;
  logic [DATA_W-1:0] rsp_result_r;
  logic              rsp_zero_r;

  // rst_n is folded in so nothing is granted or driven to the ALU during reset.
  assign can_accept_s = rst_n & (~rsp_valid_r | rsp_ready);

  rr_arb2 u_rr_arb2 (
    .req    ({req1_valid, req0_valid}),
    .last   (last_grant_r),
    .enable (can_accept_s),
    .mask   (mask_s),
    .grant  (grant_s)
  );

  assign req0_ready  = grant_s[0];
  assign req1_ready  = grant_s[1];
  assign xfer_s      = grant_s[0] | grant_s[1];
  assign grant_idx_s = grant_s[1];

  // Route the granted requester's operands to the ALU; zeros when idle.
  always_comb begin
    alu_a    = {DATA_W{1'b0}};
    alu_b    = {DATA_W{1'b0}};
    alu_ctrl = {CTRL_W{1'b0}};
    case (grant_s)
      2'b01: begin
        alu_a    = req0_a;
        alu_b    = req0_b;
        alu_ctrl = req0_ctrl;
      end
      2'b10: begin
        alu_a    = req1_a;
        alu_b    = req1_b;
        alu_ctrl = req1_ctrl;
      end
      default: begin
        alu_a    = {DATA_W{1'b0}};
        alu_b    = {DATA_W{1'b0}};
        alu_ctrl = {CTRL_W{1'b0}};
      end
    endcase
  end

`ifdef ALU_ARB_LOCK_EN
  lock_state_e state_r;
  lock_state_e state_nxt_s;
  logic        lock_sel_s;

  assign lock_sel_s = grant_idx_s ? req1_lock : req0_lock;

  // Lock state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= UNLOCKED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Lock next state: every transfer re-evaluates the lock request of its owner.
  always_comb begin
    state_nxt_s = state_r;
    if (xfer_s) begin
      if (lock_sel_s) begin
        state_nxt_s = grant_idx_s ? LOCK1 : LOCK0;
      end else begin
        state_nxt_s = UNLOCKED;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // While locked, the other requester is masked out of arbitration.
  always_comb begin
    mask_s = 2'b00;
    case (state_r)
      LOCK0:   mask_s = 2'b10;
      LOCK1:   mask_s = 2'b01;
      default: mask_s = 2'b00;
    endcase
  end
`else
  assign mask_s = 2'b00;
`endif

  // Response buffer and round-robin history; a same-cycle drain and transfer
  // simply overwrites the buffer, keeping rsp_valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= {DATA_W{1'b0}};
      rsp_zero_r   <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (xfer_s) begin
      rsp_valid_r  <= 1'b1;
      rsp_id_r     <= grant_idx_s;
      rsp_result_r <= alu_result;
      rsp_zero_r   <= alu_zero;
      last_grant_r <= grant_idx_s;
    end else if (rsp_ready && rsp_valid_r) begin
      rsp_valid_r  <= 1'b0;
    end else begin
      rsp_valid_r  <= rsp_valid_r;
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_zero   = rsp_zero_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU.
// Lock scenarios run only when ALU_ARB_LOCK_EN is defined.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        req0_lock, req1_lock;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
`ifdef ALU_ARB_LOCK_EN
    .req0_lock  (req0_lock),
    .req1_lock  (req1_lock),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  // Behavioural single-cycle ALU.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(input string tag, input logic e0, input logic e1);
    chk({tag, ".ready0"}, {63'd0, req0_ready}, {63'd0, e0});
    chk({tag, ".ready1"}, {63'd0, req1_ready}, {63'd0, e1});
  endtask

  task automatic chk_rsp(input string tag, input logic ev, input logic eid,
                         input logic [31:0] eres, input logic ez);
    chk({tag, ".rsp_valid"},  {63'd0, rsp_valid}, {63'd0, ev});
    chk({tag, ".rsp_id"},     {63'd0, rsp_id},    {63'd0, eid});
    chk({tag, ".rsp_result"}, {32'd0, rsp_result}, {32'd0, eres});
    chk({tag, ".rsp_zero"},   {63'd0, rsp_zero},  {63'd0, ez});
  endtask

  initial begin
    rst_n      = 1'b0;
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_a = 32'd5;    req0_b = 32'd7;    req0_ctrl = 4'b0010;
    req1_a = 32'hF0;   req1_b = 32'h0F;   req1_ctrl = 4'b0001;
    req0_lock = 1'b0;  req1_lock = 1'b0;

    // Reset held two cycles with both requesters valid.
    tick();
    mid();
    chk_rdy("rst", 1'b0, 1'b0);
    chk("rst.alu_a", {32'd0, alu_a}, 64'd0);
    chk_rsp("rst", 1'b0, 1'b0, 32'd0, 1'b0);
    tick();

    // First tie after release goes to req0; add 5+7.
    rst_n = 1'b1;
    mid();
    chk_rdy("first", 1'b1, 1'b0);
    chk("first.alu_a", {32'd0, alu_a}, 64'd5);
    chk("first.alu_ctrl", {60'd0, alu_ctrl}, 64'd2);
    tick();
    chk_rsp("single", 1'b1, 1'b0, 32'd12, 1'b0);

    // Backpressure: buffer full and not drained for three cycles.
    for (int i = 0; i < 3; i++) begin
      mid();
      chk_rdy("bp", 1'b0, 1'b0);
      tick();
      chk_rsp("bp", 1'b1, 1'b0, 32'd12, 1'b0);
    end

    // Drain and accept in the same cycle; req1 wins because req0 went last.
    rsp_ready = 1'b1;
    req0_a = 32'd9; req0_b = 32'd3; req0_ctrl = 4'b0110;
    mid();
    chk_rdy("drain_acc", 1'b0, 1'b1);
    tick();
    chk_rsp("drain_acc", 1'b1, 1'b1, 32'hFF, 1'b0);

    // Continuous contention alternates 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      mid();
      chk_rdy("cont", (i % 2) == 0, (i % 2) == 1);
      tick();
      chk_rsp("cont", 1'b1, (i % 2) == 1, ((i % 2) == 0) ? 32'd6 : 32'hFF, 1'b0);
    end

    // Undefined ctrl code is forwarded; behavioural ALU returns 0.
    req1_valid = 1'b0;
    req0_ctrl  = 4'b1111;
    mid();
    chk_rdy("badctl", 1'b1, 1'b0);
    chk("badctl.alu_ctrl", {60'd0, alu_ctrl}, 64'hF);
    tick();
    chk_rsp("badctl", 1'b1, 1'b0, 32'd0, 1'b1);

    // Idle drain: valid drops, data holds.
    req0_valid = 1'b0;
    req0_ctrl  = 4'b0110;
    mid();
    chk_rdy("idle", 1'b0, 1'b0);
    chk("idle.alu_a", {32'd0, alu_a}, 64'd0);
    tick();
    chk_rsp("idle", 1'b0, 1'b0, 32'd0, 1'b1);

    // req1 alone, buffer kept full, then req0 offered and withdrawn unaccepted.
    rsp_ready  = 1'b0;
    req1_valid = 1'b1;
    mid();
    chk_rdy("solo1", 1'b0, 1'b1);
    tick();
    chk_rsp("solo1", 1'b1, 1'b1, 32'hFF, 1'b0);
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    mid();
    chk_rdy("drop", 1'b0, 1'b0);
    tick();
    req0_valid = 1'b0;
    rsp_ready  = 1'b1;
    tick();
    chk("drop.rsp_valid", {63'd0, rsp_valid}, 64'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    mid();
    chk_rdy("after_drop", 1'b1, 1'b0);
    tick();
    chk_rsp("after_drop", 1'b1, 1'b0, 32'd6, 1'b0);

    // Reset mid-operation discards the buffered response and priority.
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    mid();
    chk_rdy("mrst", 1'b0, 1'b0);
    tick();
    chk_rsp("mrst", 1'b0, 1'b0, 32'd0, 1'b0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    mid();
    chk_rdy("mrst_tie", 1'b1, 1'b0);
    tick();
    chk_rsp("mrst_tie", 1'b1, 1'b0, 32'd6, 1'b0);

`ifdef ALU_ARB_LOCK_EN
    // req1 slt 2<3 with lock: holds the grant while both valid.
    req1_a = 32'd2; req1_b = 32'd3; req1_ctrl = 4'b0111; req1_lock = 1'b1;
    req0_valid = 1'b0;
    mid();
    chk_rdy("lock_in", 1'b0, 1'b1);
    tick();
    chk_rsp("lock_in", 1'b1, 1'b1, 32'd1, 1'b0);
    req0_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk_rdy("locked", 1'b0, 1'b1);
      tick();
      chk_rsp("locked", 1'b1, 1'b1, 32'd1, 1'b0);
    end
    req1_lock = 1'b0;
    mid();
    chk_rdy("unlock", 1'b0, 1'b1);
    tick();
    mid();
    chk_rdy("unlock_tie", 1'b1, 1'b0);
    tick();
    chk_rsp("unlock_tie", 1'b1, 1'b0, 32'd6, 1'b0);

    // Reset while in LOCK1 returns to UNLOCKED with req0 winning the tie.
    req0_valid = 1'b0;
    req1_lock  = 1'b1;
    mid();
    chk_rdy("relock", 1'b0, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("lrst.rsp_valid", {63'd0, rsp_valid}, 64'd0);
    rst_n      = 1'b1;
    req0_valid = 1'b1;
    mid();
    chk_rdy("lrst_tie", 1'b1, 1'b0);
    tick();
`endif

    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
